// File: rtl/filtered_ram_bank_ring_pkg.sv
// Shared types and parameter defaults for the filtered line-buffer ring.
package filtered_ram_bank_ring_pkg;

    localparam int DEF_NUM_BANKS      = 3;
    localparam int DEF_NUM_PR         = 2;
    localparam int DEF_LINE_SIZE      = 256;
    localparam int DEF_A_W            = 9;
    localparam int DEF_FDATA_W        = 12;
    localparam int DEF_FILTER_LATENCY = 4;

    // Fill-side sequencing: wait for an angle, issue addresses, wait for
    // the filter pipeline to empty, or stop after the final angle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

    // Next position around a ring of n entries.
    function automatic int ring_next(input int ptr, input int n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/filtered_ram_bank_ring_if.sv
// Host/filter handshake and processing read-port bundle.
interface filtered_ram_bank_ring_if
    import filtered_ram_bank_ring_pkg::*;
#(
    parameter int NUM_PR  = DEF_NUM_PR,
    parameter int A_W     = DEF_A_W,
    parameter int FDATA_W = DEF_FDATA_W,
    parameter int S_W     = $clog2(DEF_LINE_SIZE) + 1
);
    // host / filter side
    logic                              hs_next_angle;
    logic                              hs_angle_valid;
    logic [A_W-1:0]                    hs_angle;
    logic                              hs_has_next_angle;
    logic [S_W-1:0]                    hs_s_val;
    logic signed [FDATA_W-1:0]         hs_val;
    // processing side
    logic signed [NUM_PR*S_W-1:0]      pr_s_val;
    logic signed [NUM_PR*FDATA_W-1:0]  pr_val;
    logic                              pr_angle_valid;
    logic [A_W-1:0]                    pr_angle;
    logic                              pr_last_angle;
    logic                              pr_next_angle;

    // environment driving the ring (host + processing engine)
    modport master (
        input  hs_next_angle, hs_s_val, pr_val, pr_angle_valid, pr_angle, pr_last_angle,
        output hs_angle_valid, hs_angle, hs_has_next_angle, hs_val, pr_s_val, pr_next_angle
    );

    // the ring itself
    modport slave (
        output hs_next_angle, hs_s_val, pr_val, pr_angle_valid, pr_angle, pr_last_angle,
        input  hs_angle_valid, hs_angle, hs_has_next_angle, hs_val, pr_s_val, pr_next_angle
    );
endinterface

// File: rtl/filtered_ram_bank.sv
// One line buffer: single write port, NUM_PR registered read ports.
module filtered_ram_bank #(
    parameter int DEPTH  = 256,
    parameter int DW     = 12,
    parameter int AW     = 8,
    parameter int NUM_PR = 2
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [DW-1:0]        i_wdata,
    input  logic [NUM_PR*AW-1:0] i_raddr,
    output logic [NUM_PR*DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // filtered sample write
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar gi = 0; gi < NUM_PR; gi++) begin : g_rd
        logic [DW-1:0] r_rdata;

        // registered read for port gi
        always_ff @(posedge clk) begin
            r_rdata <= r_mem[i_raddr[gi*AW +: AW]];
        end

        assign o_rdata[gi*DW +: DW] = r_rdata;
    end

endmodule

// File: rtl/filtered_ram_bank_ring.sv
// Ring of filtered projection line buffers: one bank is filled from the
// host/filter while earlier full banks are read by the processing ports.
module filtered_ram_bank_ring
    import filtered_ram_bank_ring_pkg::*;
#(
    parameter int NUM_BANKS      = DEF_NUM_BANKS,
    parameter int NUM_PR         = DEF_NUM_PR,
    parameter int LINE_SIZE      = DEF_LINE_SIZE,
    parameter int A_W            = DEF_A_W,
    parameter int FDATA_W        = DEF_FDATA_W,
    parameter int FILTER_LATENCY = DEF_FILTER_LATENCY,
    parameter int S_W            = $clog2(LINE_SIZE) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    filtered_ram_bank_ring_if.slave  bus
);

    localparam int AW = $clog2(LINE_SIZE);
    localparam int PW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(NUM_BANKS + 1);
    localparam logic [S_W-1:0] LAST_S  = S_W'(LINE_SIZE - 1);
    localparam logic [S_W-1:0] LINE_S  = S_W'(LINE_SIZE);
    localparam logic [CW-1:0]  BANKS_C = CW'(NUM_BANKS);

    fill_state_t          r_state, w_state_next;
    logic [S_W-1:0]       r_s_cnt, w_s_cnt_next;
    logic [PW-1:0]        r_fill_ptr, r_work_ptr, r_rd_bank;
    logic [CW-1:0]        r_full_count;
    logic [A_W-1:0]       r_angle [NUM_BANKS];
    logic                 r_last  [NUM_BANKS];

    logic                 w_next_angle, w_accept, w_issue, w_retire, w_fill_done;
    logic                 w_pr_angle_valid;
    logic                 w_dly_valid;
    logic [S_W-1:0]       w_dly_addr;
    logic [NUM_PR*AW-1:0] w_raddr;
    logic [NUM_PR*FDATA_W-1:0] w_bank_rdata [NUM_BANKS];

    assign w_next_angle     = (r_state == ST_IDLE) && (r_full_count < BANKS_C);
    assign w_accept         = w_next_angle && bus.hs_angle_valid;
    assign w_issue          = (r_state == ST_ISSUE);
    assign w_pr_angle_valid = (r_full_count != '0);
    assign w_retire         = bus.pr_next_angle && w_pr_angle_valid;
    assign w_fill_done      = w_dly_valid && (w_dly_addr == LAST_S);

    assign bus.hs_next_angle  = w_next_angle;
    assign bus.hs_s_val       = w_issue ? r_s_cnt : '0;
    assign bus.pr_angle_valid = w_pr_angle_valid;
    assign bus.pr_angle       = r_angle[r_work_ptr];
    assign bus.pr_last_angle  = r_last[r_work_ptr];

    // Delay each issued address by the filter latency so the returning
    // sample lands at the address it was computed for.
    if (FILTER_LATENCY == 0) begin : g_no_dly
        assign w_dly_valid = w_issue;
        assign w_dly_addr  = r_s_cnt;
    end else begin : g_dly
        logic           r_pipe_valid [FILTER_LATENCY];
        logic [S_W-1:0] r_pipe_addr  [FILTER_LATENCY];

        // valid/address shift register, flushed by reset
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < FILTER_LATENCY; i++) begin
                    r_pipe_valid[i] <= 1'b0;
                    r_pipe_addr[i]  <= '0;
                end
            end else begin
                r_pipe_valid[0] <= w_issue;
                r_pipe_addr[0]  <= r_s_cnt;
                for (int i = FILTER_LATENCY - 1; i > 0; i--) begin
                    r_pipe_valid[i] <= r_pipe_valid[i-1];
                    r_pipe_addr[i]  <= r_pipe_addr[i-1];
                end
            end
        end

        assign w_dly_valid = r_pipe_valid[FILTER_LATENCY-1];
        assign w_dly_addr  = r_pipe_addr[FILTER_LATENCY-1];
    end

    // fill FSM next state; the last write may arrive while still in ISSUE
    // when the filter has no latency, so it overrides the normal flow
    always_comb begin
        w_state_next = r_state;
        w_s_cnt_next = r_s_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ISSUE;
                    w_s_cnt_next = '0;
                end
            end
            ST_ISSUE: begin
                if (r_s_cnt == LAST_S) begin
                    w_state_next = ST_DRAIN;
                    w_s_cnt_next = '0;
                end else begin
                    w_s_cnt_next = r_s_cnt + S_W'(1);
                end
            end
            ST_DRAIN: w_state_next = ST_DRAIN;
            ST_DONE:  w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
        if (w_fill_done) begin
            w_state_next = r_last[r_fill_ptr] ? ST_DONE : ST_IDLE;
        end
    end

    // fill FSM state and address counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_s_cnt <= w_s_cnt_next;
        end
    end

    // bank bookkeeping: angle tags, ring pointers and full-bank count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill_ptr   <= '0;
            r_work_ptr   <= '0;
            r_full_count <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_angle[i] <= '0;
                r_last[i]  <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_angle[r_fill_ptr] <= bus.hs_angle;
                r_last[r_fill_ptr]  <= !bus.hs_has_next_angle;
            end
            if (w_fill_done) begin
                r_fill_ptr <= PW'(ring_next(int'(r_fill_ptr), NUM_BANKS));
            end
            if (w_retire) begin
                r_work_ptr <= PW'(ring_next(int'(r_work_ptr), NUM_BANKS));
            end
            case ({w_fill_done, w_retire})
                2'b10:   r_full_count <= r_full_count + CW'(1);
                2'b01:   r_full_count <= r_full_count - CW'(1);
                default: r_full_count <= r_full_count;
            endcase
        end
    end

    // remember which bank the in-flight reads target, so a retire only
    // affects reads issued after it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_bank <= '0;
        end else begin
            r_rd_bank <= r_work_ptr;
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        filtered_ram_bank #(
            .DEPTH  (LINE_SIZE),
            .DW     (FDATA_W),
            .AW     (AW),
            .NUM_PR (NUM_PR)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_dly_valid && (r_fill_ptr == PW'(gi))),
            .i_waddr (w_dly_addr[AW-1:0]),
            .i_wdata (bus.hs_val),
            .i_raddr (w_raddr),
            .o_rdata (w_bank_rdata[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_PR; gi++) begin : g_rd_port
        logic [S_W-1:0] w_addr;
        logic           w_in_range;
        logic           r_rd_ok;

        assign w_addr     = bus.pr_s_val[gi*S_W +: S_W];
        assign w_in_range = !w_addr[S_W-1] && (w_addr < LINE_S);
        assign w_raddr[gi*AW +: AW] = w_addr[AW-1:0];

        // qualify the read: negative, out-of-line or no-bank reads return 0
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rd_ok <= 1'b0;
            end else begin
                r_rd_ok <= w_in_range && w_pr_angle_valid;
            end
        end

        assign bus.pr_val[gi*FDATA_W +: FDATA_W] =
            r_rd_ok ? w_bank_rdata[r_rd_bank][gi*FDATA_W +: FDATA_W] : '0;
    end

endmodule

// File: tb/tb_filtered_ram_bank_ring.sv
// Randomized bench for filtered_ram_bank_ring against a line-queue model.
module tb_filtered_ram_bank_ring;
    import filtered_ram_bank_ring_pkg::*;

    localparam int NB  = 3;
    localparam int NP  = 4;
    localparam int LS  = 256;
    localparam int AWD = 9;
    localparam int FW  = 12;
    localparam int FL  = 4;
    localparam int SW  = $clog2(LS) + 1;
    localparam int NEVER = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    filtered_ram_bank_ring_if #(.NUM_PR(NP), .A_W(AWD), .FDATA_W(FW), .S_W(SW)) bus ();

    filtered_ram_bank_ring #(
        .NUM_BANKS(NB), .NUM_PR(NP), .LINE_SIZE(LS), .A_W(AWD),
        .FDATA_W(FW), .FILTER_LATENCY(FL), .S_W(SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // model: every accepted line, oldest (working) first; a line is full
    // once the cycle counter reaches its ready time
    typedef struct {
        int id;
        int angle;
        bit last;
        int ready;
    } line_t;

    line_t q[$];
    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc = NEVER;
    int next_id = 0;
    int cur_id = 0;
    int n_checks = 0;
    int n_fail = 0;
    int ad [NP];
    logic [FW-1:0] exp_rd [NP];
    logic [SW-1:0] hist [FL+1];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, expv);
        end
    endtask

    // host filter output for sample s of line id
    function automatic logic [FW-1:0] fdata(input int id, input int s);
        return FW'(s * 3 + id * 101);
    endfunction

    function automatic int m_full();
        int n = 0;
        foreach (q[i]) if (q[i].ready <= cyc) n++;
        return n;
    endfunction

    function automatic bit m_filling();
        return (q.size() > 0) && (q[q.size()-1].ready > cyc);
    endfunction

    function automatic bit m_pr_valid();
        return (q.size() > 0) && (q[0].ready <= cyc);
    endfunction

    function automatic bit m_next_angle();
        return (cyc < done_cyc) && !m_filling() && (m_full() < NB);
    endfunction

    function automatic int m_s_val();
        if (m_filling() && (cyc - acc_cyc) < LS) return cyc - acc_cyc;
        return 0;
    endfunction

    task automatic check_outputs();
        check_val("hs_next_angle", bus.hs_next_angle, m_next_angle());
        check_val("pr_angle_valid", bus.pr_angle_valid, m_pr_valid());
        check_val("hs_s_val", bus.hs_s_val, m_s_val());
        if (m_pr_valid()) begin
            check_val("pr_angle", bus.pr_angle, q[0].angle);
            check_val("pr_last_angle", bus.pr_last_angle, q[0].last);
        end
        for (int i = 0; i < NP; i++)
            check_val($sformatf("pr_val%0d", i), bus.pr_val[i*FW +: FW], exp_rd[i]);
    endtask

    task automatic rand_addr();
        for (int i = 0; i < NP; i++) ad[i] = int'($urandom_range(0, LS + 7)) - 4;
    endtask

    // one clock: called just after a falling edge, ends at the next one
    task automatic step(input bit av, input int ang, input bit hn, input bit rn);
        bit acc;
        bit ret;
        logic signed [SW-1:0] sa;
        line_t ln;
        for (int k = FL; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = bus.hs_s_val;
        bus.hs_val            = fdata(cur_id, int'(hist[FL]));
        bus.hs_angle_valid    = av;
        bus.hs_angle          = AWD'(ang);
        bus.hs_has_next_angle = hn;
        bus.pr_next_angle     = rn;
        for (int i = 0; i < NP; i++) bus.pr_s_val[i*SW +: SW] = SW'(ad[i]);
        acc = m_next_angle() && av;
        ret = rn && m_pr_valid();
        for (int i = 0; i < NP; i++) begin
            sa = SW'(ad[i]);
            exp_rd[i] = (m_pr_valid() && int'(sa) >= 0 && int'(sa) < LS) ? fdata(q[0].id, int'(sa)) : '0;
        end
        @(posedge clk);
        cyc++;
        if (ret) begin
            $display("RETIRE id=%0d angle=%0d cyc=%0d", q[0].id, q[0].angle, cyc);
            void'(q.pop_front());
        end
        if (acc) begin
            ln.id = next_id; ln.angle = ang; ln.last = !hn; ln.ready = cyc + LS + FL;
            q.push_back(ln);
            acc_cyc = cyc;
            cur_id = next_id;
            next_id++;
            if (!hn) done_cyc = ln.ready;
            $display("ACCEPT id=%0d angle=%0d last=%0d cyc=%0d", ln.id, ang, !hn, cyc);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_idle();
        bus.hs_angle_valid = 1'b0; bus.hs_angle = '0; bus.hs_has_next_angle = 1'b1;
        bus.hs_val = '0; bus.pr_s_val = '0; bus.pr_next_angle = 1'b0;
    endtask

    // called at time 0 or just after a falling edge
    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc += 2;
        q.delete();
        done_cyc = NEVER;
        for (int i = 0; i < NP; i++) exp_rd[i] = '0;
        check_outputs();
        check_val("rst_pr_angle", bus.pr_angle, 0);
        check_val("rst_pr_last", bus.pr_last_angle, 0);
        $display("RESET cyc=%0d", cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int rise;
        bit coinc;
        drive_idle();
        for (int k = 0; k <= FL; k++) hist[k] = '0;
        do_reset();

        // first line: angle 5, data s*3, latency to full
        for (int i = 0; i < NP; i++) ad[i] = 0;
        step(1'b1, 5, 1'b1, 1'b0);
        acc0 = cyc;
        rise = -1;
        for (int k = 0; k < LS + FL + 2; k++) begin
            rand_addr();
            step(1'b0, 0, 1'b1, 1'b0);
            if (rise < 0 && bus.pr_angle_valid === 1'b1) rise = cyc;
        end
        check_val("valid_latency", rise - acc0, LS + FL);
        ad[0] = 10; ad[1] = 20; ad[2] = 255; ad[3] = 0;
        step(1'b0, 0, 1'b1, 1'b0);
        check_val("pr_val_s10", bus.pr_val[FW-1:0], 30);
        ad[0] = -1; ad[1] = 256; ad[2] = 5; ad[3] = 100;
        step(1'b0, 0, 1'b1, 1'b0);

        // fill every bank with no retire, then free one
        for (int k = 0; k < 3000 && m_full() < NB; k++) begin
            rand_addr();
            step(1'b1, int'($urandom_range(0, 511)), 1'b1, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            rand_addr();
            step(1'b1, int'($urandom_range(0, 511)), 1'b1, 1'b0);
        end
        check_val("full_blocks_accept", bus.hs_next_angle, 0);
        rand_addr();
        step(1'b1, 7, 1'b1, 1'b1);
        check_val("retire_unblocks", bus.hs_next_angle, 1);

        // random traffic
        for (int k = 0; k < 2500; k++) begin
            rand_addr();
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 511)), 1'b1,
                 ($urandom_range(0, 99) < 3));
        end

        // fill-complete coinciding with a retire
        coinc = 1'b0;
        for (int k = 0; k < 3000 && !coinc; k++) begin
            bit rn;
            rn = (m_filling() && q[q.size()-1].ready == cyc + 1 && m_pr_valid()) || (m_full() == NB);
            if (m_filling() && q[q.size()-1].ready == cyc + 1 && m_pr_valid()) coinc = 1'b1;
            rand_addr();
            step(1'b1, int'($urandom_range(0, 511)), 1'b1, rn);
        end
        for (int k = 0; k < 20; k++) begin
            rand_addr();
            step(1'b0, 0, 1'b1, 1'b0);
        end

        // reset in the middle of a fill
        do_reset();
        step(1'b1, 77, 1'b1, 1'b0);
        for (int k = 0; k < 200 && m_s_val() != 100; k++) begin
            rand_addr();
            step(1'b0, 0, 1'b1, 1'b0);
        end
        do_reset();
        step(1'b1, 33, 1'b1, 1'b0);
        for (int k = 0; k < LS + FL + 40; k++) begin
            rand_addr();
            step(1'b0, 0, 1'b1, 1'b0);
        end

        // final angle: DONE and no further requests
        step(1'b1, 200, 1'b0, 1'b0);
        for (int k = 0; k < LS + FL + 40; k++) begin
            rand_addr();
            step(1'b1, int'($urandom_range(0, 511)), 1'b1, 1'b0);
        end
        rand_addr();
        step(1'b1, 1, 1'b1, 1'b1);
        check_val("done_last", bus.pr_last_angle, 1);
        for (int k = 0; k < 30; k++) begin
            rand_addr();
            step(1'b1, int'($urandom_range(0, 511)), 1'b1, 1'b0);
        end
        check_val("done_no_request", bus.hs_next_angle, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filtered_ram_bank_ring.md
FILTERED_RAM_BANK_RING -- requirements
Module: filtered_ram_bank_ring

Interface
REQ-001 Parameter NUM_BANKS, default 3: number of line buffers in the ring, legal range 2..8.
REQ-002 Parameter NUM_PR, default 2: number of processing read ports, legal range 1..8.
REQ-003 Parameter LINE_SIZE, default 256: samples per projection line.
REQ-004 Parameters A_W=9, FDATA_W=12 and S_W=clog2(LINE_SIZE)+1: angle width, filtered data width and signed s width.
REQ-005 Parameter FILTER_LATENCY, default 4: cycles from hs_s_val issue to the matching hs_val, legal range 0..15.
REQ-006 Ports clk (in, 1) and reset (in, 1); one clock; reset is synchronous and active-high.
REQ-007 Port hs_next_angle (out, 1): requests the next angle from the host.
REQ-008 Port hs_angle_valid (in, 1): host acknowledges the request and hs_angle is valid.
REQ-009 Port hs_angle (in, A_W): angle belonging to the line being filled.
REQ-010 Port hs_has_next_angle (in, 1): sampled at accept; low marks the accepted angle as the last.
REQ-011 Port hs_s_val (out, S_W): RAM address issued to the host/filter.
REQ-012 Port hs_val (in, FDATA_W, signed): filtered sample.
REQ-013 Port pr_s_val (in, NUM_PR*S_W, signed, packed): read addresses, port i at slice i.
REQ-014 Port pr_val (out, NUM_PR*FDATA_W, signed, packed): read data.
REQ-015 Ports pr_angle_valid (out, 1), pr_angle (out, A_W) and pr_last_angle (out, 1): describe the current working bank.
REQ-016 Port pr_next_angle (in, 1): processing retires the working bank.

Function
REQ-017 Fill FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-018 hs_next_angle SHALL equal (state==IDLE && full_count<NUM_BANKS).
REQ-019 Accept occurs on the cycle hs_next_angle && hs_angle_valid.
- Latch hs_angle and !hs_has_next_angle into bank fill_ptr.
- Transition to ISSUE.
REQ-020 ISSUE: hs_s_val steps 0..LINE_SIZE-1, one per cycle, starting the cycle after accept; transition to DRAIN after LINE_SIZE-1 is issued.
REQ-021 Each issued address SHALL be delayed FILTER_LATENCY cycles by an internal valid/address pipeline; hs_val is written at that delayed address in bank fill_ptr.
REQ-022 DRAIN: on the write of address LINE_SIZE-1:
- mark the bank full;
- advance fill_ptr modulo NUM_BANKS;
- go to DONE if the angle was the last, otherwise to IDLE.
REQ-023 DONE is held until reset; hs_next_angle stays low in DONE.
REQ-024 Fill latency from accept to bank full is LINE_SIZE+FILTER_LATENCY cycles.
REQ-025 pr_angle_valid SHALL equal (full_count>0); pr_angle and pr_last_angle come from bank work_ptr.
REQ-026 pr_next_angle with pr_angle_valid high retires the bank: full_count decrements, work_ptr advances modulo NUM_BANKS. pr_next_angle with pr_angle_valid low is ignored.
REQ-027 A fill-complete and a retire in the same cycle leave full_count unchanged while both pointers advance.
REQ-028 full_count SHALL never exceed NUM_BANKS; the bank being filled is never the working bank.
REQ-029 pr_val[i] is registered one cycle after pr_s_val[i], read from the working bank.
REQ-030 pr_val[i] SHALL be 0 if pr_s_val[i]<0, pr_s_val[i]>=LINE_SIZE, or pr_angle_valid was low on the address cycle.
REQ-031 A retire takes effect for reads from the next cycle; the registered read issued in the retire cycle still uses the old bank.
REQ-032 When not in ISSUE, hs_s_val SHALL hold 0.

Reset
REQ-033 Reset SHALL produce the following state:
- state=IDLE, fill_ptr=work_ptr=full_count=0;
- delay pipeline flushed;
- hs_next_angle=1 on the cycle after reset;
- hs_s_val=0, pr_angle_valid=0, pr_angle=0, pr_last_angle=0, pr_val all 0.
REQ-034 Reset mid-fill SHALL discard in-flight hs_val and leave no bank marked full; RAM contents are not cleared.

Structure
REQ-035 A shared package SHALL hold the fill-state enum and the parameter defaults (NUM_BANKS, NUM_PR, LINE_SIZE, A_W, FDATA_W, FILTER_LATENCY).
REQ-036 Sub-module filtered_ram_bank SHALL provide a 1-write, NUM_PR-read synchronous RAM of depth LINE_SIZE.
- Instantiate it NUM_BANKS times.
- Select the write and read banks via fill_ptr and work_ptr.

Verification
REQ-037 Defaults: accept angle 5 with hs_val=s*3 -> pr_angle_valid rises 260 cycles after accept; pr_s_val=10 gives pr_val=30 one cycle later.
REQ-038 Fill 3 angles with no retire -> full_count=3 and hs_next_angle low; one pr_next_angle -> hs_next_angle high next cycle.
REQ-039 Fill-complete and pr_next_angle in the same cycle -> full_count unchanged; work_ptr and fill_ptr both advance; data from the new bank is read correctly.
REQ-040 pr_s_val=-1 and 256 on ports 0 and 1 -> pr_val=0 on both; NUM_PR=4 with distinct addresses -> four independent correct values.
REQ-041 hs_has_next_angle=0 at accept -> pr_last_angle=1 for that bank; FSM reaches DONE; hs_next_angle stays 0 thereafter.
REQ-042 Reset asserted at s=100 mid-fill -> full_count=0 and pr_angle_valid=0; the next fill completes with correct data.
